// File: rtl/nap_timer_bank.sv
// Multi-channel BCD HH:MM:SS nap countdown bank with a shared 1 s tick,
// per-channel load/start/pause/cancel/snooze/ack lifecycle and bounded ring period.
module nap_timer_bank #(
    parameter int CHANNELS     = 2,
    parameter int CH_W         = 1,
    parameter int TICK_DIV     = 50000000,
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_TIMEOUT = 60
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CH_W-1:0]     cmd_ch,
    input  logic                load,
    input  logic [23:0]         load_time,
    input  logic                start,
    input  logic                pause,
    input  logic                cancel,
    input  logic                snooze,
    input  logic                ack,
    input  logic [CH_W-1:0]     disp_ch,
    output logic [23:0]         disp_time,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] ringing,
    output logic                any_ring,
    output logic [CHANNELS-1:0] done,
    output logic                load_err,
    output logic                tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RC_W  = $clog2(RING_TIMEOUT + 1);
    localparam int unsigned NCH = CHANNELS;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
    localparam logic [RC_W-1:0]  RING_LAST   = RC_W'(RING_TIMEOUT - 1);
    localparam logic [23:0]      SNOOZE_TIME = {8'h00, 4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10), 8'h00};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADED,
        ST_RUN,
        ST_PAUSE,
        ST_RING
    } state_t;

    state_t              state_q [CHANNELS];
    logic [23:0]         time_q  [CHANNELS];
    logic [RC_W-1:0]     ring_q  [CHANNELS];
    logic [DIV_W-1:0]    div_q;
    logic [CHANNELS-1:0] done_q;
    logic                err_q;
    logic [CHANNELS-1:0] hit;
    logic                any_cmd;
    logic                load_ok;
    logic                cmd_err;

    function automatic logic time_valid(input logic [23:0] t);
        logic ok;
        ok = 1'b1;
        for (int unsigned d = 0; d < 6; d++) begin
            if (t[d*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (t[23:20] > 4'd2) ok = 1'b0;
        if (t[23:20] == 4'd2 && t[19:16] > 4'd3) ok = 1'b0;
        if (t[15:12] > 4'd5) ok = 1'b0;
        if (t[7:4] > 4'd5) ok = 1'b0;
        return ok;
    endfunction

    // Ripple borrow from s1 upward; a zero digit wraps to its own maximum.
    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [23:0] r;
        logic        borrow;
        r      = t;
        borrow = 1'b1;
        for (int unsigned d = 0; d < 6; d++) begin
            if (borrow) begin
                if (r[d*4 +: 4] != 4'd0) begin
                    r[d*4 +: 4] = r[d*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end else begin
                    r[d*4 +: 4] = (d == 1 || d == 3) ? 4'd5 : (d == 5) ? 4'd2 : 4'd9;
                end
            end
        end
        return r;
    endfunction

    assign any_cmd = cancel | load | start | pause | snooze | ack;
    assign load_ok = time_valid(load_time);

    always_comb begin
        hit     = '0;
        cmd_err = 1'b0;
        if (any_cmd) begin
            if (32'(cmd_ch) >= NCH) cmd_err = 1'b1;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (32'(cmd_ch) == i) begin
                    hit[i] = 1'b1;
                    if (!cancel) begin
                        if (load)
                            cmd_err = !(state_q[i] inside {ST_IDLE, ST_LOADED, ST_PAUSE}) || !load_ok;
                        else if (start)
                            cmd_err = !(state_q[i] inside {ST_LOADED, ST_PAUSE}) || (time_q[i] == '0);
                        else if (pause)
                            cmd_err = (state_q[i] != ST_RUN);
                        else
                            cmd_err = (state_q[i] != ST_RING);
                    end
                end
            end
        end
    end

    always_comb begin
        running   = '0;
        ringing   = '0;
        disp_time = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            running[i] = (state_q[i] == ST_RUN);
            ringing[i] = (state_q[i] == ST_RING);
            if (32'(disp_ch) == i) disp_time = time_q[i];
        end
    end

    assign any_ring = |ringing;
    assign done     = done_q;
    assign load_err = err_q;
    assign tick     = (div_q == DIV_LAST);

    // An addressed channel acts on its command and skips any coincident tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                time_q[i]  <= '0;
                ring_q[i]  <= '0;
            end
        end else begin
            div_q  <= tick ? '0 : div_q + 1'b1;
            err_q  <= cmd_err;
            done_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (hit[i]) begin
                    if (cancel) begin
                        state_q[i] <= ST_IDLE;
                        time_q[i]  <= '0;
                        ring_q[i]  <= '0;
                    end else if (load) begin
                        if ((state_q[i] inside {ST_IDLE, ST_LOADED, ST_PAUSE}) && load_ok) begin
                            time_q[i]  <= load_time;
                            state_q[i] <= ST_LOADED;
                        end
                    end else if (start) begin
                        if ((state_q[i] inside {ST_LOADED, ST_PAUSE}) && time_q[i] != '0)
                            state_q[i] <= ST_RUN;
                    end else if (pause) begin
                        if (state_q[i] == ST_RUN) state_q[i] <= ST_PAUSE;
                    end else if (snooze) begin
                        if (state_q[i] == ST_RING) begin
                            state_q[i] <= ST_RUN;
                            time_q[i]  <= SNOOZE_TIME;
                        end
                    end else if (ack) begin
                        if (state_q[i] == ST_RING) state_q[i] <= ST_IDLE;
                    end
                end else if (tick) begin
                    case (state_q[i])
                        ST_RUN: begin
                            if (time_q[i] == 24'h000001) begin
                                time_q[i]  <= '0;
                                state_q[i] <= ST_RING;
                                done_q[i]  <= 1'b1;
                                ring_q[i]  <= '0;
                            end else begin
                                time_q[i] <= bcd_dec(time_q[i]);
                            end
                        end
                        ST_RING: begin
                            if (ring_q[i] == RING_LAST) begin
                                state_q[i] <= ST_IDLE;
                                ring_q[i]  <= '0;
                            end else begin
                                ring_q[i] <= ring_q[i] + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_nap_timer_bank.sv
// Bench for nap_timer_bank: command table plus scoreboarded sequences
// covering countdown, snooze, ring timeout, tick/command collisions and reset.
module tb_nap_timer_bank;

    localparam int TD = 4;
    localparam logic [5:0] C_CANCEL = 6'b100000;
    localparam logic [5:0] C_LOAD   = 6'b010000;
    localparam logic [5:0] C_START  = 6'b001000;
    localparam logic [5:0] C_PAUSE  = 6'b000100;
    localparam logic [5:0] C_SNOOZE = 6'b000010;
    localparam logic [5:0] C_ACK    = 6'b000001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd_ch = '0;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0;
    logic        cancel = 1'b0, snooze = 1'b0, ack = 1'b0;
    logic [23:0] load_time = '0;
    logic [1:0]  disp_ch = '0;
    logic [23:0] disp_time;
    logic [1:0]  running, ringing, done;
    logic        any_ring, load_err, tick;

    always #5 clock = ~clock;

    nap_timer_bank #(
        .CHANNELS(2), .CH_W(2), .TICK_DIV(TD), .SNOOZE_MIN(5), .RING_TIMEOUT(3)
    ) dut (
        .clock(clock), .reset(reset), .cmd_ch(cmd_ch), .load(load),
        .load_time(load_time), .start(start), .pause(pause), .cancel(cancel),
        .snooze(snooze), .ack(ack), .disp_ch(disp_ch), .disp_time(disp_time),
        .running(running), .ringing(ringing), .any_ring(any_ring), .done(done),
        .load_err(load_err), .tick(tick)
    );

    typedef struct {
        string       name;
        logic        err;
        logic [23:0] disp;
        logic [1:0]  run;
        logic [1:0]  ring;
        logic [1:0]  dn;
    } exp_t;

    typedef struct {
        string       name;
        logic [5:0]  cmds;
        logic [1:0]  ch;
        logic [23:0] t;
        logic        err;
        logic [23:0] disp;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mdiv = 0;
    int   done0_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference divider: the edge following a negedge with mdiv == TD-1 carries the tick.
    always @(posedge clock) mdiv <= reset ? 0 : ((mdiv == TD - 1) ? 0 : mdiv + 1);

    always @(negedge clock) begin
        chk("tick", 32'(tick), 32'(mdiv == TD - 1));
        if (done[0] === 1'b1) done0_cnt++;
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic drive(input logic [5:0] c, input logic [1:0] ch, input logic [23:0] t);
        {cancel, load, start, pause, snooze, ack} = c;
        cmd_ch    = ch;
        load_time = t;
    endtask

    task automatic avoid_tick();
        if (mdiv == TD - 1) cyc();
    endtask

    task automatic align_tick();
        int guard;
        guard = 0;
        while (mdiv != TD - 1 && guard < 2 * TD) begin
            cyc();
            guard++;
        end
        if (mdiv != TD - 1) begin
            n_errors++;
            $display("FAIL align_tick: no tick within %0d cycles", 2 * TD);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            align_tick();
            cyc();
        end
    endtask

    task automatic check_sb();
        exp_t e;
        if (sbq.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: empty queue, got 0 entries, expected 1");
        end else begin
            e = sbq.pop_front();
            chk({e.name, " load_err"}, 32'(load_err), 32'(e.err));
            chk({e.name, " disp"}, 32'(disp_time), 32'(e.disp));
            chk({e.name, " running"}, 32'(running), 32'(e.run));
            chk({e.name, " ringing"}, 32'(ringing), 32'(e.ring));
            chk({e.name, " any_ring"}, 32'(any_ring), 32'(|e.ring));
            chk({e.name, " done"}, 32'(done), 32'(e.dn));
        end
    endtask

    task automatic issue(input string name, input logic [5:0] c, input logic [1:0] ch,
                         input logic [23:0] t, input logic err, input logic [23:0] disp,
                         input logic [1:0] run, input logic [1:0] ring, input bit raw);
        if (!raw) avoid_tick();
        drive(c, ch, t);
        sbq.push_back('{name, err, disp, run, ring, 2'b00});
        cyc();
        drive('0, '0, '0);
        check_sb();
    endtask

    task automatic check_disp(input string name, input logic [1:0] ch, input logic [23:0] exp);
        disp_ch = ch;
        #1;
        chk(name, 32'(disp_time), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        repeat (3) cyc();
        chk("rst load_err", 32'(load_err), 0);
        chk("rst running", 32'(running), 0);
        chk("rst ringing", 32'(ringing), 0);
        chk("rst any_ring", 32'(any_ring), 0);
        chk("rst done", 32'(done), 0);
        check_disp("rst disp0", 2'd0, 24'h000000);
        check_disp("rst disp1", 2'd1, 24'h000000);
        disp_ch = 2'd0;
        reset   = 1'b0;

        // Channel 0: short countdown, expiry, snooze, second expiry, ring timeout.
        issue("A load", C_LOAD, 2'd0, 24'h000003, 1'b0, 24'h000003, 2'b00, 2'b00, 1'b0);
        issue("A start", C_START, 2'd0, '0, 1'b0, 24'h000003, 2'b01, 2'b00, 1'b0);
        wait_ticks(1);
        chk("A t1 disp", 32'(disp_time), 32'h000002);
        wait_ticks(2);
        chk("A exp disp", 32'(disp_time), 32'h000000);
        chk("A exp ringing", 32'(ringing), 32'b01);
        chk("A exp any_ring", 32'(any_ring), 1);
        chk("A exp running", 32'(running), 0);
        chk("A exp done", 32'(done), 32'b01);
        cyc();
        chk("A done cleared", 32'(done), 0);
        chk("A done count", 32'(done0_cnt), 1);
        issue("A snooze", C_SNOOZE, 2'd0, '0, 1'b0, 24'h000500, 2'b01, 2'b00, 1'b0);
        wait_ticks(1);
        chk("A snz t1", 32'(disp_time), 32'h000459);
        wait_ticks(60);
        chk("A snz t61", 32'(disp_time), 32'h000359);
        wait_ticks(239);
        chk("A snz exp disp", 32'(disp_time), 32'h000000);
        chk("A snz exp ringing", 32'(ringing), 32'b01);
        chk("A snz exp done", 32'(done), 32'b01);
        cyc();
        chk("A done count 2", 32'(done0_cnt), 2);
        wait_ticks(2);
        chk("A ring hold", 32'(ringing), 32'b01);
        wait_ticks(1);
        chk("A timeout ringing", 32'(ringing), 0);
        chk("A timeout running", 32'(running), 0);
        chk("A timeout done", 32'(done), 0);
        cyc();
        chk("A timeout no done", 32'(done0_cnt), 2);

        // Channel 1: hour borrow, pause holds, resume continues.
        disp_ch = 2'd1;
        issue("B load", C_LOAD, 2'd1, 24'h010000, 1'b0, 24'h010000, 2'b00, 2'b00, 1'b0);
        issue("B start", C_START, 2'd1, '0, 1'b0, 24'h010000, 2'b10, 2'b00, 1'b0);
        wait_ticks(1);
        chk("B t1", 32'(disp_time), 32'h005959);
        check_disp("B disp ch2", 2'd2, 24'h000000);
        check_disp("B disp ch3", 2'd3, 24'h000000);
        disp_ch = 2'd1;
        issue("B pause", C_PAUSE, 2'd1, '0, 1'b0, 24'h005959, 2'b00, 2'b00, 1'b0);
        wait_ticks(5);
        chk("B paused", 32'(disp_time), 32'h005959);
        issue("B resume", C_START, 2'd1, '0, 1'b0, 24'h005959, 2'b10, 2'b00, 1'b0);
        wait_ticks(1);
        chk("B t2", 32'(disp_time), 32'h005958);

        // Command table on channel 0 while channel 1 keeps running.
        disp_ch = 2'd0;
        vecs.push_back('{"ld 245900", C_LOAD, 2'd0, 24'h245900, 1'b1, 24'h000000});
        vecs.push_back('{"ld 006000", C_LOAD, 2'd0, 24'h006000, 1'b1, 24'h000000});
        vecs.push_back('{"ld 00A000", C_LOAD, 2'd0, 24'h00A000, 1'b1, 24'h000000});
        vecs.push_back('{"ld 240000", C_LOAD, 2'd0, 24'h240000, 1'b1, 24'h000000});
        vecs.push_back('{"ld 001960", C_LOAD, 2'd0, 24'h001960, 1'b1, 24'h000000});
        vecs.push_back('{"ld 00000A", C_LOAD, 2'd0, 24'h00000A, 1'b1, 24'h000000});
        vecs.push_back('{"ld 195959", C_LOAD, 2'd0, 24'h195959, 1'b0, 24'h195959});
        vecs.push_back('{"ld 235959", C_LOAD, 2'd0, 24'h235959, 1'b0, 24'h235959});
        vecs.push_back('{"pause loaded", C_PAUSE, 2'd0, '0, 1'b1, 24'h235959});
        vecs.push_back('{"snooze loaded", C_SNOOZE, 2'd0, '0, 1'b1, 24'h235959});
        vecs.push_back('{"ack loaded", C_ACK, 2'd0, '0, 1'b1, 24'h235959});
        vecs.push_back('{"load+start", C_LOAD | C_START, 2'd0, 24'h000007, 1'b0, 24'h000007});
        vecs.push_back('{"start ch1 run", C_START, 2'd1, '0, 1'b1, 24'h000007});
        vecs.push_back('{"load ch1 run", C_LOAD, 2'd1, 24'h000001, 1'b1, 24'h000007});
        vecs.push_back('{"load ch2", C_LOAD, 2'd2, 24'h000001, 1'b1, 24'h000007});
        vecs.push_back('{"cancel ch3", C_CANCEL, 2'd3, '0, 1'b1, 24'h000007});
        vecs.push_back('{"cancel+load", C_CANCEL | C_LOAD, 2'd0, 24'h123456, 1'b0, 24'h000000});
        vecs.push_back('{"start idle", C_START, 2'd0, '0, 1'b1, 24'h000000});
        vecs.push_back('{"pause idle", C_PAUSE, 2'd0, '0, 1'b1, 24'h000000});
        vecs.push_back('{"ld 000000", C_LOAD, 2'd0, 24'h000000, 1'b0, 24'h000000});
        vecs.push_back('{"start zero", C_START, 2'd0, '0, 1'b1, 24'h000000});
        foreach (vecs[i])
            issue(vecs[i].name, vecs[i].cmds, vecs[i].ch, vecs[i].t, vecs[i].err,
                  vecs[i].disp, 2'b10, 2'b00, 1'b0);

        // Cancel ch0 on the tick edge: ch0 clears, ch1 still decrements.
        issue("D cancel ch1", C_CANCEL, 2'd1, '0, 1'b0, 24'h000000, 2'b00, 2'b00, 1'b0);
        issue("D load ch1", C_LOAD, 2'd1, 24'h000100, 1'b0, 24'h000000, 2'b00, 2'b00, 1'b0);
        issue("D load ch0", C_LOAD, 2'd0, 24'h000030, 1'b0, 24'h000030, 2'b00, 2'b00, 1'b0);
        align_tick();
        cyc();
        issue("D start ch1", C_START, 2'd1, '0, 1'b0, 24'h000030, 2'b10, 2'b00, 1'b1);
        issue("D start ch0", C_START, 2'd0, '0, 1'b0, 24'h000030, 2'b11, 2'b00, 1'b1);
        cyc();
        chk("D tick phase", 32'(mdiv), TD - 1);
        issue("D cancel@tick", C_CANCEL, 2'd0, '0, 1'b0, 24'h000000, 2'b10, 2'b00, 1'b1);
        check_disp("D ch1 after tick", 2'd1, 24'h000059);
        disp_ch = 2'd0;
        issue("D start zero", C_START, 2'd0, '0, 1'b1, 24'h000000, 2'b10, 2'b00, 1'b0);

        // Reset with ch0 ringing, ch1 running and an error pulse pending.
        issue("E load", C_LOAD, 2'd0, 24'h000001, 1'b0, 24'h000001, 2'b10, 2'b00, 1'b0);
        issue("E start", C_START, 2'd0, '0, 1'b0, 24'h000001, 2'b11, 2'b00, 1'b0);
        wait_ticks(1);
        chk("E ringing", 32'(ringing), 32'b01);
        chk("E running", 32'(running), 32'b10);
        chk("E done", 32'(done), 32'b01);
        reset = 1'b1;
        drive(C_PAUSE, 2'd0, '0);
        cyc();
        drive('0, '0, '0);
        chk("E rst load_err", 32'(load_err), 0);
        chk("E rst done", 32'(done), 0);
        chk("E rst running", 32'(running), 0);
        chk("E rst ringing", 32'(ringing), 0);
        chk("E rst any_ring", 32'(any_ring), 0);
        check_disp("E rst disp0", 2'd0, 24'h000000);
        check_disp("E rst disp1", 2'd1, 24'h000000);
        reset = 1'b0;
        n = 0;
        while (n < 3 * TD) begin
            cyc();
            n++;
            if (tick) break;
        end
        chk("E first tick latency", 32'(n), TD - 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nap_timer_bank.md
Name: nap_timer_bank

Overview:
- Parametrised multi-channel nap countdown engine; successor to the single-channel time register plus sleep/alarm sequencing in the nap machine top level.
- Holds CHANNELS independent BCD HH:MM:SS countdowns. Each channel has a load/start/pause/cancel/snooze/acknowledge lifecycle and a bounded ring period.
- Sits between keypad/setting logic (time source) and the display rotator, lullaby and alarm sound/light blocks (consumers of disp_time, running, ringing and done).

Parameters:
- CHANNELS, 2, number of independent timer channels (1..8).
- CH_W, 1, channel index width; must satisfy 2^CH_W >= CHANNELS.
- TICK_DIV, 50000000, clock cycles per 1 s tick.
- SNOOZE_MIN, 5, snooze duration in minutes (1..59), loaded as 00:MM:00.
- RING_TIMEOUT, 60, seconds a channel rings before auto-returning to IDLE.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- cmd_ch  in  CH_W  channel addressed by load/start/pause/cancel/snooze/ack
- load  in  1  one-cycle pulse: load load_time into cmd_ch
- load_time  in  24  BCD {h10,h1,m10,m1,s10,s1}, 4 bits each
- start  in  1  pulse: start or resume cmd_ch
- pause  in  1  pulse: pause cmd_ch
- cancel  in  1  pulse: abort cmd_ch to IDLE
- snooze  in  1  pulse: snooze a ringing cmd_ch
- ack  in  1  pulse: acknowledge a ringing cmd_ch
- disp_ch  in  CH_W  channel shown on disp_time
- disp_time  out  24  BCD remaining time of disp_ch
- running  out  CHANNELS  bit per channel, 1 in RUN
- ringing  out  CHANNELS  bit per channel, 1 in RING
- any_ring  out  1  OR of ringing
- done  out  CHANNELS  one-cycle pulse when a channel reaches 00:00:00
- load_err  out  1  one-cycle pulse: rejected load or command
- tick  out  1  one-cycle 1 s strobe, shared by all channels

Behaviour:
- Single clock domain.
- Reset: all channels IDLE with time 000000. Tick divider is 0. All outputs are 0.
- Tick: free-running counter 0..TICK_DIV-1; tick asserts for 1 cycle when the counter equals TICK_DIV-1, then the counter wraps to 0. The counter is not affected by commands.
- Per-channel FSM states: IDLE, LOADED, RUN, PAUSE, RING.
- load is accepted in IDLE, LOADED and PAUSE only:
  - Validity: every digit <= 9, h10 <= 2, hour <= 23, m10 <= 5, s10 <= 5.
  - Valid load: time is stored next cycle and the state becomes LOADED (from PAUSE as well).
  - Invalid digits, or load while in RUN/RING: time unchanged and load_err pulses.
- start: LOADED/PAUSE -> RUN if time != 0. If time == 0, or the channel is in IDLE/RUN/RING, load_err pulses and there is no change.
- pause: RUN -> PAUSE. In any other state, load_err pulses.
- cancel: any state -> IDLE, time cleared to 0. Never raises an error.
- Decrement: in RUN, on tick, time decrements by 1 s with BCD borrow. s1 9..0; s10 5..0; m1 9..0; m10 5..0; h1 9..0 (h1 3..0 when h10=2 is never needed on decrement); h10 2..0.
  - Example: 01:00:00 -> 00:59:59.
- Expiry: decrement from 00:00:01 yields 00:00:00. The same clock edge sets RING and pulses done[ch]; the ring-seconds counter is cleared.
- RING:
  - ringing[ch] = 1; time holds 000000.
  - The ring counter increments on each tick. When it reaches RING_TIMEOUT the channel goes to IDLE with no done pulse.
  - ack -> IDLE.
  - snooze -> RUN with time 00:SNOOZE_MIN:00 in BCD.
  - snooze or ack outside RING: load_err pulses.
- Command priority within one cycle: reset > cancel > load > start > pause > snooze > ack. The first asserted command acts on cmd_ch and the rest are ignored without error.
- Command and tick in the same cycle: the addressed channel executes the command and skips that tick's decrement/ring count. Unaddressed channels process the tick normally.
- Channels other than cmd_ch are never affected by commands.
- cmd_ch >= CHANNELS: every command raises load_err and no state changes.
- disp_time: combinational mux of the registered time of disp_ch. disp_ch >= CHANNELS gives 000000.
- running, ringing, any_ring: decoded from registered state, zero added latency.
- done, load_err: registered pulses, asserted the cycle after the causing edge's decision (visible one cycle after the input pulse).
- Reset mid-operation: all channels immediately return to IDLE and any pending done/load_err pulse is suppressed.

Test Plan:
- TICK_DIV=4, CHANNELS=2: load ch0 000003, start -> running[0]=1; after 3 ticks time=000000, done[0] pulses once, ringing[0]=1, any_ring=1.
- Load ch1 010000, start, 1 tick -> disp_time (disp_ch=1) = 005959; pause, 5 ticks -> still 005959; start resumes the countdown.
- Load 245900, 006000 and 00A000 in turn -> each gives load_err pulse and the state is unchanged; load 235959 is accepted.
- Ringing ch0 with SNOOZE_MIN=5: snooze -> time 000500, RUN. Let it expire again; with no ack, after RING_TIMEOUT ticks -> IDLE, ringing[0]=0.
- Both channels RUN; cancel ch0 in the same cycle as tick -> ch0 IDLE/000000, ch1 decrements by 1; start with time 0 -> load_err.
- Reset asserted while ch0 RING and ch1 RUN -> next cycle all outputs 0 and tick counter restarts (first tick after TICK_DIV cycles).
